// File: rtl/mat_vec_mac_seq.sv
// mat_vec_mac_seq: sequential matrix-vector multiplier, y[i] = sum_j x[j]*M[j][i].
// One multiply-accumulate per clock. The coefficient matrix is run-time
// writable while idle. Results stream out one element per valid/ready handshake.
module mat_vec_mac_seq #(
  parameter int N  = 6,
  parameter int W  = 8,
  parameter int XW = 1,
  localparam int IW = $clog2(N),
  localparam int AW = W + XW + $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*XW-1:0] in_vec,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            w_we,
  input  logic [IW-1:0]   w_row,
  input  logic [IW-1:0]   w_col,
  input  logic [W-1:0]    w_data,
  output logic [AW-1:0]   out_data,
  output logic [IW-1:0]   out_idx,
  output logic            out_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, MAC, EMIT} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t            state;
  state_t            state_next;
  logic [W-1:0]      m [N][N];
  logic [N*XW-1:0]   x_lat;
  logic [IW-1:0]     i_cnt;
  logic [IW-1:0]     j_cnt;
  logic [AW-1:0]     acc;
  logic [XW-1:0]     x_elem;
  logic [AW-1:0]     acc_sum;
  logic              w_in_range;

  // Current product term added to the running sum; full width, cannot wrap.
  assign x_elem     = x_lat[j_cnt*XW +: XW];
  assign acc_sum    = acc + (AW'(x_elem) * AW'(m[j_cnt][i_cnt]));
  assign w_in_range = ({1'b0, w_row} < (IW+1)'(N)) && ({1'b0, w_col} < (IW+1)'(N));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (in_valid)          state_next = MAC;
      MAC:     if (j_cnt == LAST_IDX) state_next = EMIT;
      EMIT:    if (out_ready)         state_next = (i_cnt == LAST_IDX) ? IDLE : MAC;
      default:                        state_next = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == EMIT);
    busy      = (state != IDLE);
  end

  // Coefficient matrix: default pattern on reset, writes only while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the matrix is reset explicitly because its default pattern is architectural, not a don't-care.
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          m[r][c] <= W'(r * 16 + c + 1);
        end
      end
    end else if (state == IDLE && w_we && w_in_range) begin
      m[w_row][w_col] <= w_data;
    end
  end

  // Datapath: vector latch, counters, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_lat    <= '0;
      i_cnt    <= '0;
      j_cnt    <= '0;
      acc      <= '0;
      out_data <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_lat <= in_vec;
            i_cnt <= '0;
            j_cnt <= '0;
            acc   <= '0;
          end
        end
        MAC: begin
          acc   <= acc_sum;
          j_cnt <= j_cnt + 1'b1;
          if (j_cnt == LAST_IDX) begin
            out_data <= acc_sum;
            out_idx  <= i_cnt;
            out_last <= (i_cnt == LAST_IDX);
          end
        end
        EMIT: begin
          // Result registers are untouched here, so data is stable under backpressure.
          if (out_ready && i_cnt != LAST_IDX) begin
            i_cnt <= i_cnt + 1'b1;
            j_cnt <= '0;
            acc   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_vec_mac_seq.sv
// Directed testbench for mat_vec_mac_seq: default 6x6 binary-vector instance
// plus a 4x4 instance with 4-bit vector elements.
module tb_mat_vec_mac_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Default instance: N=6, W=8, XW=1 (IW=3, AW=12).
  logic [5:0]  in_vec;
  logic        in_valid, in_ready;
  logic        w_we;
  logic [2:0]  w_row, w_col;
  logic [7:0]  w_data;
  logic [11:0] out_data;
  logic [2:0]  out_idx;
  logic        out_last, out_valid, out_ready, busy;

  mat_vec_mac_seq dut (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid), .in_ready(in_ready),
    .w_we(w_we), .w_row(w_row), .w_col(w_col), .w_data(w_data),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  // Wide instance: N=4, W=8, XW=4 (IW=2, AW=14).
  logic [15:0] in_vec2;
  logic        in_valid2, in_ready2;
  logic        w_we2;
  logic [1:0]  w_row2, w_col2;
  logic [7:0]  w_data2;
  logic [13:0] out_data2;
  logic [1:0]  out_idx2;
  logic        out_last2, out_valid2, out_ready2, busy2;

  mat_vec_mac_seq #(.N(4), .W(8), .XW(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec2), .in_valid(in_valid2), .in_ready(in_ready2),
    .w_we(w_we2), .w_row(w_row2), .w_col(w_col2), .w_data(w_data2),
    .out_data(out_data2), .out_idx(out_idx2), .out_last(out_last2),
    .out_valid(out_valid2), .out_ready(out_ready2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a vector for one cycle; returns the cycle count of the accept edge.
  task automatic send(input logic [5:0] v, output int t_acc);
    in_vec   = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    t_acc    = cyc;
  endtask

  // Wait (bounded) for out_valid, check the element, then step past the handshake if ready.
  task automatic get_out(input string tag, input int exp_data, input int exp_idx,
                         input bit exp_last, output int t_seen);
    for (int k = 0; k < 100 && !out_valid; k++) @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(out_data),  32'(exp_data));
    check({tag, "_idx"},   32'(out_idx),   32'(exp_idx));
    check({tag, "_last"},  32'(out_last),  32'(exp_last));
    t_seen = cyc;
    if (out_ready) @(negedge clk);
  endtask

  task automatic write_m(input int r, input int c, input int d);
    w_we   = 1'b1;
    w_row  = 3'(r);
    w_col  = 3'(c);
    w_data = 8'(d);
    @(negedge clk);
    w_we   = 1'b0;
  endtask

  initial begin
    int t_acc, t_seen, t_prev, t_hs;
    int exp_y [6];

    rst_n = 1'b0; in_vec = '0; in_valid = 1'b0; out_ready = 1'b1;
    w_we = 1'b0; w_row = '0; w_col = '0; w_data = '0;
    in_vec2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b1;
    w_we2 = 1'b0; w_row2 = '0; w_col2 = '0; w_data2 = '0;

    // Reset state, during and after reset.
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // All-ones vector: y[i] = sum_j (16j+i+1) = 246 + 6i.
    send(6'b111111, t_acc);
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 6; i++) begin
      t_prev = t_seen;
      get_out("ones", 246 + 6 * i, i, i == 5, t_seen);
      if (i == 0) check("first_latency", 32'(t_seen - t_acc), 32'd6);
      else        check("ones_spacing", 32'(t_seen - t_prev), 32'd7);
    end
    check("ones_in_ready_back", 32'(in_ready), 32'd1);

    // One-hot x[2]: y[i] = 33 + i.
    send(6'b000100, t_acc);
    for (int i = 0; i < 6; i++) get_out("onehot", 33 + i, i, i == 5, t_seen);

    // Backpressure on idx 2.
    send(6'b000100, t_acc);
    get_out("bp", 33, 0, 1'b0, t_seen);
    get_out("bp", 34, 1, 1'b0, t_seen);
    out_ready = 1'b0;
    get_out("bp_hold", 35, 2, 1'b0, t_seen);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_stable_data", 32'(out_data), 32'd35);
      check("bp_stable_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    check("bp_stable_idx", 32'(out_idx), 32'd2);
    out_ready = 1'b1;
    t_hs = cyc;
    @(negedge clk);
    get_out("bp_after", 36, 3, 1'b0, t_seen);
    check("bp_resume_gap", 32'(t_seen - t_hs), 32'd7);
    get_out("bp_after", 37, 4, 1'b0, t_seen);
    get_out("bp_after", 38, 5, 1'b1, t_seen);

    // Write M[2][4]=200 while idle.
    exp_y = '{33, 34, 35, 36, 200, 38};
    write_m(2, 4, 200);
    send(6'b000100, t_acc);
    for (int i = 0; i < 6; i++) get_out("wr200", exp_y[i], i, i == 5, t_seen);

    // Write of 0 during MAC is dropped.
    send(6'b000100, t_acc);
    write_m(2, 4, 0);
    for (int i = 0; i < 6; i++) get_out("wr_busy", exp_y[i], i, i == 5, t_seen);

    // Out-of-range row write is dropped.
    write_m(7, 4, 0);
    write_m(6, 4, 0);
    send(6'b000100, t_acc);
    for (int i = 0; i < 6; i++) get_out("wr_oob", exp_y[i], i, i == 5, t_seen);

    // Reset while in EMIT at idx 3.
    send(6'b000100, t_acc);
    for (int i = 0; i < 3; i++) get_out("prerst", exp_y[i], i, 1'b0, t_seen);
    out_ready = 1'b0;
    get_out("prerst", 36, 3, 1'b0, t_seen);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    send(6'b000100, t_acc);
    for (int i = 0; i < 6; i++) get_out("midrst_default", 33 + i, i, i == 5, t_seen);

    // Wide instance: all M=255, all x=15 -> y = 4*255*15 = 15300.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_we2 = 1'b1; w_row2 = 2'(r); w_col2 = 2'(c); w_data2 = 8'd255;
        @(negedge clk);
      end
    end
    w_we2 = 1'b0;
    in_vec2 = 16'hFFFF;
    in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 100 && !out_valid2; k++) @(negedge clk);
      check("wide_valid", 32'(out_valid2), 32'd1);
      check("wide_data", 32'(out_data2), 32'd15300);
      check("wide_idx", 32'(out_idx2), 32'(i));
      check("wide_last", 32'(out_last2), 32'(i == 3));
      @(negedge clk);
    end
    check("wide_in_ready_back", 32'(in_ready2), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
